// File: rtl/move_history_display_pkg.sv
// Shared glyph tables, history entry type and legal move-code ranges
// for the chess move history display.
package chess_disp_pkg;

  localparam logic [3:0] FILE_MIN = 4'd8;
  localparam logic [3:0] RANK_MAX = 4'd7;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Index is the 3-bit code: rank 1..8, file A..H
  localparam logic [6:0] RANK_GLYPH [8] = '{
    7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00
  };

  localparam logic [6:0] FILE_GLYPH [8] = '{
    7'h08, 7'h03, 7'h46, 7'h21,
    7'h06, 7'h0E, 7'h42, 7'h09
  };

  typedef struct packed {
    logic [2:0] file;
    logic [2:0] rank;
    logic       valid;
  } hist_entry_t;

  function automatic logic code_legal(
    input logic [3:0] x,
    input logic [3:0] y
  );
    return (x >= FILE_MIN) && (y <= RANK_MAX);
  endfunction

endpackage

// File: rtl/move_history_display_if.sv
// Move-report inputs and display outputs of the move history display.
interface move_history_display_if;

  logic       move_strobe;
  logic [3:0] last_x;
  logic [3:0] last_y;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       bad_code;
  logic [2:0] move_count;

  modport master (
    output move_strobe,
    output last_x,
    output last_y,
    input  an,
    input  seg,
    input  dp,
    input  bad_code,
    input  move_count
  );

  modport slave (
    input  move_strobe,
    input  last_x,
    input  last_y,
    output an,
    output seg,
    output dp,
    output bad_code,
    output move_count
  );

endinterface

// File: rtl/move_history_display_glyph_rom.sv
// Maps a history field (file letter or rank number) to an
// active-low seven-segment glyph; invalid entries are blank.
module move_glyph_rom
  import chess_disp_pkg::*;
(
  input  logic       i_is_file,
  input  logic [2:0] i_code,
  input  logic       i_valid,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_BLANK;
    unique case (1'b1)
      !i_valid:
        o_seg = GLYPH_BLANK;
      i_valid && i_is_file:
        o_seg = FILE_GLYPH[i_code];
      i_valid && !i_is_file:
        o_seg = RANK_GLYPH[i_code];
      default:
        o_seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/move_history_display.sv
// Four-move history on an eight-digit multiplexed display.
// Define MOVE_HISTORY_CHANGE_DETECT_EN to capture on input change.
module move_history_display
  import chess_disp_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input logic                   clk,
  input logic                   rst,
  move_history_display_if.slave bus
);

  localparam int DW =
    (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(REFRESH_CYCLES - 1);

  hist_entry_t [3:0] r_hist;
  logic [2:0]        r_count;
  logic              r_bad;
  logic [DW-1:0]     r_div;
  logic [2:0]        r_dig;
  logic [7:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic        w_cap;
  logic        w_legal;
  hist_entry_t w_new;
  hist_entry_t w_ent;
  logic [6:0]  w_seg;

`ifdef MOVE_HISTORY_CHANGE_DETECT_EN
  logic [7:0] r_prev;
  logic       w_unused;

  assign w_unused = bus.move_strobe;
  assign w_cap =
    {bus.last_x, bus.last_y} != r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= 8'h00;
    end else begin
      r_prev <= {bus.last_x, bus.last_y};
    end
  end
`else
  assign w_cap = bus.move_strobe;
`endif

  assign w_legal = code_legal(bus.last_x, bus.last_y);

  always_comb begin
    w_new       = '0;
    w_new.file  = bus.last_x[2:0];
    w_new.rank  = bus.last_y[2:0];
    w_new.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= '0;
      r_count <= 3'd0;
      r_bad   <= 1'b0;
    end else begin
      r_bad <= w_cap && !w_legal;
      if (w_cap && w_legal) begin
        r_hist <= {r_hist[2:0], w_new};
        if (r_count != 3'd4) begin
          r_count <= r_count + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
      r_dig <= 3'd0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
      r_dig <= r_dig + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Odd digits show the file letter, even digits the rank
  assign w_ent = r_hist[r_dig[2:1]];

  move_glyph_rom u_rom (
    .i_is_file (r_dig[0]),
    .i_code    (r_dig[0] ? w_ent.file : w_ent.rank),
    .i_valid   (w_ent.valid),
    .o_seg     (w_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 8'hFF;
      r_seg <= GLYPH_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_ent.valid ? ~(8'h01 << r_dig) : 8'hFF;
      r_seg <= w_seg;
      r_dp  <= !((r_dig == 3'd0) && r_hist[0].valid);
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.bad_code   = r_bad;
  assign bus.move_count = r_count;

endmodule

// File: tb/tb_move_history_display.sv
// Directed bench for move_history_display with REFRESH_CYCLES=4.
module tb_move_history_display;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [6:0] s_seg [8];
  logic       s_dp  [8];
  logic [7:0] seen;
  int         an_bad;

  logic [6:0] e_seg [8];
  logic       e_dp  [8];
  logic [7:0] e_seen;

  move_history_display_if bus ();

  move_history_display #(
    .REFRESH_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    bus.move_strobe = 1'b0;
    bus.last_x = 4'h0;
    bus.last_y = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_strobe(input logic [3:0] x,
                           input logic [3:0] y);
    bus.last_x = x;
    bus.last_y = y;
    bus.move_strobe = 1'b1;
    @(posedge clk);
    #1 bus.move_strobe = 1'b0;
  endtask

  // Observes one full scan (32 cycles) plus margin
  task automatic scan();
    bit found;
    seen = '0;
    an_bad = 0;
    for (int d = 0; d < 8; d++) begin
      s_seg[d] = 7'h7F;
      s_dp[d] = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.an != 8'hFF) begin
        found = 0;
        for (int d = 0; d < 8; d++) begin
          if (bus.an == 8'(~(8'h01 << d))) begin
            seen[d] = 1'b1;
            s_seg[d] = bus.seg;
            s_dp[d] = bus.dp;
            found = 1;
          end
        end
        if (!found) an_bad++;
      end
    end
  endtask

  task automatic compare_scan(input string name);
    checks++;
    if (seen !== e_seen || an_bad != 0) begin
      failures++;
      $display("FAIL %s digits: got %b (bad an %0d) want %b",
               name, seen, an_bad, e_seen);
    end
    for (int d = 0; d < 8; d++) begin
      if (e_seen[d]) begin
        checks++;
        if (s_seg[d] !== e_seg[d] || s_dp[d] !== e_dp[d]) begin
          failures++;
          $display("FAIL %s digit%0d: seg %h dp %b want %h %b",
                   name, d, s_seg[d], s_dp[d], e_seg[d], e_dp[d]);
        end
      end
    end
  endtask

  task automatic set_exp(input logic [7:0] sn,
                         input logic [55:0] sg);
    e_seen = sn;
    for (int d = 0; d < 8; d++) begin
      e_seg[d] = sg[d*7 +: 7];
      e_dp[d] = (d != 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== 8'hFF || bus.seg !== 7'h7F ||
          bus.dp !== 1'b1 || bus.move_count !== 3'd0) begin
        failures++;
        $display("FAIL reset c%0d: an %h seg %h dp %b cnt %0d",
                 c, bus.an, bus.seg, bus.dp, bus.move_count);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    do_strobe(4'hC, 4'h3);
    checks++;
    if (bus.move_count !== 3'd1) begin
      failures++;
      $display("FAIL single count: got %0d want 1",
               bus.move_count);
    end
    scan();
    // digit1 = E (file code C), digit0 = rank 4
    set_exp(8'h03, {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                    7'h7F, 7'h7F, 7'h06, 7'h19});
    compare_scan("single");
  endtask

  task automatic test_full();
    do_strobe(4'h8, 4'h0);
    do_strobe(4'h9, 4'h1);
    do_strobe(4'hA, 4'h2);
    do_strobe(4'hB, 4'h3);
    do_strobe(4'hF, 4'h7);
    checks++;
    if (bus.move_count !== 3'd4) begin
      failures++;
      $display("FAIL full count: got %0d want 4",
               bus.move_count);
    end
    scan();
    // digits 7..0: b 2 C 3 d 4 H 8
    set_exp(8'hFF, {7'h03, 7'h24, 7'h46, 7'h30,
                    7'h21, 7'h19, 7'h09, 7'h00});
    compare_scan("full");
  endtask

  task automatic test_bad();
    logic [3:0] bx [2];
    logic [3:0] by [2];
    bx[0] = 4'h5; by[0] = 4'h2;
    bx[1] = 4'h9; by[1] = 4'h8;
    for (int i = 0; i < 2; i++) begin
      do_strobe(bx[i], by[i]);
      @(negedge clk);
      checks++;
      if (bus.bad_code !== 1'b1) begin
        failures++;
        $display("FAIL bad%0d pulse: got %b want 1",
                 i, bus.bad_code);
      end
      @(negedge clk);
      checks++;
      if (bus.bad_code !== 1'b0 || bus.move_count !== 3'd4) begin
        failures++;
        $display("FAIL bad%0d after: bad %b cnt %0d want 0 4",
                 i, bus.bad_code, bus.move_count);
      end
    end
    scan();
    compare_scan("bad_hist");
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.an !== 8'hFF || bus.seg !== 7'h7F ||
        bus.dp !== 1'b1 || bus.bad_code !== 1'b0 ||
        bus.move_count !== 3'd0) begin
      failures++;
      $display("FAIL async_rst: an %h seg %h dp %b bad %b cnt %0d",
               bus.an, bus.seg, bus.dp, bus.bad_code,
               bus.move_count);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.last_x = 4'h8;
    bus.last_y = 4'h0;
    bus.move_strobe = 1'b1;
    @(posedge clk);
    #1;
    bus.last_x = 4'hF;
    bus.last_y = 4'h7;
    @(posedge clk);
    #1 bus.move_strobe = 1'b0;
    checks++;
    if (bus.move_count !== 3'd2) begin
      failures++;
      $display("FAIL b2b count: got %0d want 2",
               bus.move_count);
    end
    scan();
    // digits 3..0: A 1 H 8
    set_exp(8'h0F, {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                    7'h08, 7'h79, 7'h09, 7'h00});
    compare_scan("b2b");
  endtask

  task automatic test_change_detect();
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    bus.last_x = 4'hB;
    bus.last_y = 4'h4;
    @(posedge clk);
    #1;
    checks++;
    if (bus.move_count !== 3'd1) begin
      failures++;
      $display("FAIL cd capture: got %0d want 1",
               bus.move_count);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus.move_count !== 3'd1 || bus.bad_code !== 1'b0) begin
      failures++;
      $display("FAIL cd hold: cnt %0d bad %b want 1 0",
               bus.move_count, bus.bad_code);
    end
    scan();
    // digit1 = d, digit0 = rank 5
    set_exp(8'h03, {7'h7F, 7'h7F, 7'h7F, 7'h7F,
                    7'h7F, 7'h7F, 7'h21, 7'h12});
    compare_scan("cd");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
`ifdef MOVE_HISTORY_CHANGE_DETECT_EN
    test_change_detect();
    test_async_reset();
`else
    test_single();
    test_reset();
    test_full();
    test_bad();
    test_async_reset();
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
